decode_control_pipe: RTL
========================

DECODE_CONTROL_PIPE -- requirements
Module: decode_control_pipe

Interface
REQ-001 The block SHALL have parameter ALU_OP_WIDTH, default 4: width of alu_op; valid range 4..8, upper bits zero-extended from the 4-bit encoding.
REQ-002 The block SHALL have parameter MD_LATENCY, default 4: busy cycles for MULT/DIV; valid range 1..15.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have ports opcode[5:0], funct[5:0] and reg_rt_id[4:0], inputs: instruction fields from decode; encodings per mips.h.
REQ-006 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): the instruction handshake; the instruction is accepted when both are high.
REQ-007 The block SHALL have ports stall (input, 1): hold the ID/EX register; and flush (input, 1): insert a bubble.
REQ-008 The block SHALL have ports out_valid, reg_write, mem_to_reg, mem_write, mem_byte, alu_src, reg_dest, branch, jump, jump_reg and jump_link, outputs, 1 bit each: registered EX-stage controls.
REQ-009 The block SHALL have port alu_op[ALU_OP_WIDTH-1:0], output: registered ALU operation.
REQ-010 The block SHALL have port md_busy, output, 1: a multiply/divide is in flight.

Function
REQ-011 Decode SHALL be combinational: branch = BEQ | BNE | (REGIMM & rt==BLTZ); jump = J | JAL | JR; mem_write = SW | SB; mem_byte = SB; mem_to_reg = LW; jump_reg = JR; jump_link = JAL.
REQ-012 reg_write SHALL be 1 for SPECIAL (except JR, MULT, DIV), ADDIU, ORI, LUI, LW and JAL; it SHALL be 0 for SW and SB.
REQ-013 alu_src SHALL be 1 for I-type and SPECIAL SLL/SRA; reg_dest SHALL be 1 for R-type.
REQ-014 in_ready SHALL be !stall & !flush & !md_hold; md_hold is 1 while md_busy is 1 and the input is MFHI, MFLO, MULT or DIV.
REQ-015 Priority per edge SHALL be flush > stall > accept > bubble.
REQ-016 On flush, the next cycle SHALL give out_valid = 0 and all control outputs = 0.
REQ-017 Under stall without flush, every output register SHALL hold its value.
REQ-018 On accept, the decoded controls SHALL appear one cycle later with out_valid = 1 (latency 1).
REQ-019 With no accept, stall or flush, the next cycle SHALL be a bubble: out_valid = 0 and all controls = 0.
REQ-020 The MD state machine SHALL have states MD_IDLE and MD_BUSY; md_busy SHALL be 1 exactly in MD_BUSY.
REQ-021 In MD_IDLE, an accepted MULT or DIV SHALL load the counter with MD_LATENCY and move the FSM to MD_BUSY.
REQ-022 In MD_BUSY, the counter SHALL decrement each cycle regardless of stall or flush; at count 1 the FSM SHALL return to MD_IDLE on the next edge.
REQ-023 A held MULT/DIV SHALL be accepted on the first cycle md_busy is 0 (back-to-back MULT/DIV, no overlap).
REQ-024 Non-MD instructions SHALL be accepted while md_busy is 1.

Reset
REQ-025 While reset is 1, all outputs SHALL be 0, including out_valid and md_busy; the FSM SHALL be in MD_IDLE with counter 0.
REQ-026 Reset asserted mid-multiply SHALL abort it immediately; in_ready SHALL reflect only stall/flush after the first post-reset edge.

Configuration
REQ-027 Macro MULDIV_EN SHALL compile the MD state machine, counter and md_hold in.
REQ-028 Without MULDIV_EN, md_busy SHALL be tied 0, md_hold SHALL be 0, and MULT/DIV/MFHI/MFLO SHALL decode with reg_write = 0 (no-op).

Verification
REQ-029 Reset, then ADDIU (6'h09) valid, no stall -> next cycle out_valid=1, reg_write=1, alu_src=1, reg_dest=0.
REQ-030 SW (6'h2B), then SB (6'h28) -> mem_write=1 and reg_write=0 for both; mem_byte=0 then 1.
REQ-031 LW accepted, stall=1 for 3 cycles -> mem_to_reg=1 and out_valid=1 held all 3 cycles, in_ready=0; flush on cycle 4 -> out_valid=0.
REQ-032 MULT (SPECIAL, funct 6'h18) with MD_LATENCY=4, then MFLO (funct 6'h12) -> md_busy=1 for 4 cycles, in_ready=0 for MFLO until md_busy falls, then MFLO accepted; an ADDU issued during busy is accepted immediately.
REQ-033 Assert reset during the 2nd busy cycle of DIV (funct 6'h1A) -> md_busy=0 and all outputs 0 asynchronously; after release, MFHI is accepted on the first cycle.
REQ-034 Build without MULDIV_EN, issue MULT then MFLO -> md_busy stays 0, both accepted back-to-back, reg_write=0 for both.

Source files
------------

// File: rtl/decode_control_pipe.sv
// decode_control_pipe: MIPS ID-stage control decode feeding a registered ID/EX
// control register, with an optional multiply/divide busy tracker.
// Optional feature macro: MULDIV_EN builds the MD state machine, its counter
// and the MFHI/MFLO/MULT/DIV hold. Without it, those instructions decode as no-ops.
module decode_control_pipe #(
  parameter int unsigned ALU_OP_WIDTH = 4,
  parameter int unsigned MD_LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic [4:0]              reg_rt_id,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    out_valid,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic                    mem_write,
  output logic                    mem_byte,
  output logic                    alu_src,
  output logic                    reg_dest,
  output logic                    branch,
  output logic                    jump,
  output logic                    jump_reg,
  output logic                    jump_link,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    md_busy
);

  // Opcode, funct and rt encodings (mips.h)
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J   = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE = 6'h05,
                         OP_ADDIU   = 6'h09, OP_ORI    = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW      = 6'h23, OP_SB     = 6'h28, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_JR   = 6'h08, FN_MFHI = 6'h10, FN_MFLO = 6'h12,
                         FN_MULT = 6'h18, FN_DIV  = 6'h1A, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [4:0] RT_BLTZ = 5'h00;

  // 4-bit ALU operation encoding, zero-extended onto alu_op
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,  ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6,  ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

`ifdef MULDIV_EN
  localparam logic MD_WRITE = 1'b1;
`else
  localparam logic MD_WRITE = 1'b0;
`endif

  // Elaboration-time guard on the parameter ranges
  if (ALU_OP_WIDTH < 4 || ALU_OP_WIDTH > 8 || MD_LATENCY < 1 || MD_LATENCY > 15) begin : g_param_check
    $error("decode_control_pipe: parameter out of range");
  end

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_byte;
    logic       alu_src;
    logic       reg_dest;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       jump_link;
    logic [3:0] alu_op;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_q;
  logic  valid_q;
  logic  md_hold;
  logic  accept;

  assign in_ready = !reset && !stall && !flush && !md_hold;
  assign accept   = in_valid && in_ready;

  // Combinational instruction decode
  always_comb begin
    dec = '0;
    case (opcode)
      OP_SPECIAL: begin
        dec.reg_dest  = 1'b1;
        dec.reg_write = 1'b1;
        case (funct)
          FN_SLL:  begin dec.alu_src = 1'b1; dec.alu_op = ALU_SLL; end
          FN_SRL:  dec.alu_op = ALU_SRL;
          FN_SRA:  begin dec.alu_src = 1'b1; dec.alu_op = ALU_SRA; end
          FN_JR:   begin dec.reg_write = 1'b0; dec.jump = 1'b1; dec.jump_reg = 1'b1; end
          FN_MULT, FN_DIV: dec.reg_write = 1'b0;
          FN_MFHI, FN_MFLO: dec.reg_write = MD_WRITE;
          FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_NOR:  dec.alu_op = ALU_NOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLTU: dec.alu_op = ALU_SLTU;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (reg_rt_id == RT_BLTZ) begin
          dec.branch = 1'b1;
          dec.alu_op = ALU_SLT;
        end
      end
      OP_J:     dec.jump = 1'b1;
      OP_JAL:   begin dec.jump = 1'b1; dec.jump_link = 1'b1; dec.reg_write = 1'b1; end
      OP_BEQ, OP_BNE: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
      OP_ADDIU: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
      OP_ORI:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_OR; end
      OP_LUI:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_LUI; end
      OP_LW:    begin dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1; end
      OP_SW:    begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
      OP_SB:    begin dec.mem_write = 1'b1; dec.mem_byte = 1'b1; dec.alu_src = 1'b1; end
      default: ;
    endcase
  end

  // ID/EX control register: flush beats stall beats accept beats bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!stall) begin
      valid_q <= accept;
      if (accept) ctrl_q <= dec;
      else        ctrl_q <= '0;
    end
  end

  assign out_valid  = valid_q;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_write  = ctrl_q.mem_write;
  assign mem_byte   = ctrl_q.mem_byte;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_dest   = ctrl_q.reg_dest;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign jump_reg   = ctrl_q.jump_reg;
  assign jump_link  = ctrl_q.jump_link;
  assign alu_op     = ALU_OP_WIDTH'(ctrl_q.alu_op);

`ifdef MULDIV_EN
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

  md_state_t  md_state;
  logic [3:0] md_cnt;
  logic       is_muldiv;
  logic       is_md_use;

  assign is_muldiv = (opcode == OP_SPECIAL) && ((funct == FN_MULT) || (funct == FN_DIV));
  assign is_md_use = is_muldiv ||
                     ((opcode == OP_SPECIAL) && ((funct == FN_MFHI) || (funct == FN_MFLO)));
  assign md_hold   = md_busy && is_md_use;

  // Multiply/divide busy tracker; counts down independent of stall/flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      md_busy  <= 1'b0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (accept && is_muldiv) begin
            md_state <= MD_BUSY;
            md_cnt   <= 4'(MD_LATENCY);
            md_busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          md_cnt <= md_cnt - 4'd1;
          if (md_cnt == 4'd1) begin
            md_state <= MD_IDLE;
            md_busy  <= 1'b0;
          end
        end
      endcase
    end
  end
`else
  assign md_hold = 1'b0;
  assign md_busy = 1'b0;
`endif

endmodule
